// File: rtl/sdram_aref_if.sv
// Refresh-stage handshake with the SDRAM arbiter plus the command/address it muxes onto the bus.
// Signal prefixes are from the refresh generator's point of view (slave modport).
interface sdram_aref_if;
    logic        i_init_end;
    logic        i_ref_en;
    logic        o_ref_req;
    logic        o_ref_end;
    logic [3:0]  o_aref_cmd;
    logic [11:0] o_aref_addr;
    logic        o_ref_miss;

    modport slave (
        input  i_init_end,
        input  i_ref_en,
        output o_ref_req,
        output o_ref_end,
        output o_aref_cmd,
        output o_aref_addr,
        output o_ref_miss
    );

    modport master (
        output i_init_end,
        output i_ref_en,
        input  o_ref_req,
        input  o_ref_end,
        input  o_aref_cmd,
        input  o_aref_addr,
        input  o_ref_miss
    );
endinterface

// File: rtl/sdram_aref.sv
// SDRAM auto-refresh generator: periodic request, PRE-ALL / tRP / AREF / tRC sequence, done pulse.
// Define SDRAM_AREF_DOUBLE_EN to issue two AUTO-REFRESH commands per grant.
module sdram_aref #(
    parameter int REF_PERIOD = 750,
    parameter int TRP_CYC    = 2,
    parameter int TRC_CYC    = 7,
    parameter int CNT_W      = 10
) (
    input  logic        clk,
    input  logic        rst,
    sdram_aref_if.slave bus
);

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_PRE  = 4'b0010;
    localparam logic [3:0]  CMD_AREF = 4'b0001;
    localparam logic [11:0] ADDR_ALL_BANKS = 12'h400;

    localparam int WAIT_MAX = (TRC_CYC > TRP_CYC) ? TRC_CYC : TRP_CYC;
    localparam int WAIT_W   = $clog2(WAIT_MAX) + 1;
    localparam logic [WAIT_W-1:0] TRP_LAST   = WAIT_W'(TRP_CYC - 1);
    localparam logic [WAIT_W-1:0] TRC_LAST   = WAIT_W'(TRC_CYC - 1);
    localparam logic [CNT_W-1:0]  TIMER_LAST = CNT_W'(REF_PERIOD - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_TRP,
        ST_AREF,
        ST_TRC,
`ifdef SDRAM_AREF_DOUBLE_EN
        ST_AREF2,
        ST_TRC2,
`endif
        ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_timer;
    logic              r_ref_req;
    logic              r_ref_miss;
    logic              r_ref_end;
    logic [3:0]        r_cmd;
    logic [11:0]       r_addr;
    logic [3:0]        w_cmd;
    logic [11:0]       w_addr;
    logic              w_grant;
    logic              w_tc;

    assign w_grant = (r_state == ST_IDLE) && r_ref_req && bus.i_ref_en;
    assign w_tc    = (r_timer == TIMER_LAST);

    // Outputs are decoded from the next state so the registered command lines up with the state.
    always_comb begin
        w_next = r_state;
        w_cmd  = CMD_NOP;
        w_addr = 12'h000;
        case (r_state)
            ST_IDLE:  if (w_grant) w_next = ST_PRE;
            ST_PRE:   w_next = ST_TRP;
            ST_TRP:   if (r_wait == TRP_LAST) w_next = ST_AREF;
            ST_AREF:  w_next = ST_TRC;
`ifdef SDRAM_AREF_DOUBLE_EN
            ST_TRC:   if (r_wait == TRC_LAST) w_next = ST_AREF2;
            ST_AREF2: w_next = ST_TRC2;
            ST_TRC2:  if (r_wait == TRC_LAST) w_next = ST_DONE;
`else
            ST_TRC:   if (r_wait == TRC_LAST) w_next = ST_DONE;
`endif
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase

        if (w_next == ST_PRE) begin
            w_cmd  = CMD_PRE;
            w_addr = ADDR_ALL_BANKS;
        end
`ifdef SDRAM_AREF_DOUBLE_EN
        if (w_next == ST_AREF || w_next == ST_AREF2) w_cmd = CMD_AREF;
`else
        if (w_next == ST_AREF) w_cmd = CMD_AREF;
`endif
    end

    // The wait counter restarts whenever the state changes, so each wait state counts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_wait    <= '0;
            r_cmd     <= CMD_NOP;
            r_addr    <= 12'h000;
            r_ref_end <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wait    <= (w_next != r_state) ? '0 : r_wait + WAIT_W'(1);
            r_cmd     <= w_cmd;
            r_addr    <= w_addr;
            r_ref_end <= (w_next == ST_DONE);
        end
    end

    // Terminal count wins over a same-cycle grant, so a request raised then is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer    <= '0;
            r_ref_req  <= 1'b0;
            r_ref_miss <= 1'b0;
        end else if (!bus.i_init_end) begin
            r_timer   <= '0;
            r_ref_req <= 1'b0;
        end else begin
            r_timer <= w_tc ? '0 : r_timer + CNT_W'(1);
            if (w_tc) begin
                r_ref_req <= 1'b1;
                if (r_ref_req && !w_grant) r_ref_miss <= 1'b1;
            end else if (w_grant) begin
                r_ref_req <= 1'b0;
            end
        end
    end

    assign bus.o_ref_req   = r_ref_req;
    assign bus.o_ref_end   = r_ref_end;
    assign bus.o_aref_cmd  = r_cmd;
    assign bus.o_aref_addr = r_addr;
    assign bus.o_ref_miss  = r_ref_miss;

endmodule

// File: tb/tb_sdram_aref.sv
// Bench for sdram_aref: one instance at the default period, one at REF_PERIOD=20, both
// compared every cycle against an offset-from-grant reference model under random stimulus.
module tb_sdram_aref;

    localparam int TRP   = 2;
    localparam int TRC   = 7;
    localparam int PER_A = 750;
    localparam int PER_B = 20;
`ifdef SDRAM_AREF_DOUBLE_EN
    localparam int NAREF = 2;
`else
    localparam int NAREF = 1;
`endif
    localparam int AREF1_OFF = 2 + TRP;
    localparam int AREF_GAP  = 1 + TRC;
    localparam int END_OFF   = AREF1_OFF + NAREF * AREF_GAP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic initEnd [2];
    logic refEn [2];
    bit   checkEn = 1'b0;

    int vectorCount = 0;
    int miscompareCount = 0;

    int mElapsed [2] = '{0, 0};
    int mOff [2] = '{-1, -1};
    bit mReq [2] = '{1'b0, 1'b0};
    bit mMiss [2] = '{1'b0, 1'b0};
    int period [2] = '{PER_A, PER_B};

    always #5 clk = ~clk;

    sdram_aref_if busA ();
    sdram_aref_if busB ();

    assign busA.i_init_end = initEnd[0];
    assign busA.i_ref_en   = refEn[0];
    assign busB.i_init_end = initEnd[1];
    assign busB.i_ref_en   = refEn[1];

    sdram_aref dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    sdram_aref #(
        .REF_PERIOD (PER_B),
        .CNT_W      (5)
    ) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            miscompareCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] expCmd(input int off);
        if (off == 1) return 4'b0010;
        if (off >= AREF1_OFF && off < END_OFF && ((off - AREF1_OFF) % AREF_GAP) == 0)
            return 4'b0001;
        return 4'b0111;
    endfunction

    function automatic logic [11:0] expAddr(input int off);
        return (off == 1) ? 12'h400 : 12'h000;
    endfunction

    // Model state: cycles of init_end high, pending request, sticky miss, cycles since grant.
    task automatic modelStep(input int d, input bit r, input bit ie, input bit en);
        bit grant;
        bit tc;
        if (r) begin
            mElapsed[d] = 0;
            mReq[d]     = 1'b0;
            mMiss[d]    = 1'b0;
            mOff[d]     = -1;
            return;
        end
        grant = (mOff[d] < 0) && mReq[d] && en;
        if (!ie) begin
            mElapsed[d] = 0;
            mReq[d]     = 1'b0;
        end else begin
            tc = (mElapsed[d] % period[d]) == period[d] - 1;
            mElapsed[d]++;
            if (tc) begin
                if (mReq[d] && !grant) mMiss[d] = 1'b1;
                mReq[d] = 1'b1;
            end else if (grant) begin
                mReq[d] = 1'b0;
            end
        end
        if (grant) mOff[d] = 1;
        else if (mOff[d] >= 0) mOff[d] = (mOff[d] == END_OFF) ? -1 : mOff[d] + 1;
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) modelStep(d, rst, initEnd[d], refEn[d]);
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("A.ref_req",   busA.o_ref_req,   mReq[0]);
            checkOutput("A.ref_end",   busA.o_ref_end,   mOff[0] == END_OFF);
            checkOutput("A.aref_cmd",  busA.o_aref_cmd,  expCmd(mOff[0]));
            checkOutput("A.aref_addr", busA.o_aref_addr, expAddr(mOff[0]));
            checkOutput("A.ref_miss",  busA.o_ref_miss,  mMiss[0]);
            checkOutput("B.ref_req",   busB.o_ref_req,   mReq[1]);
            checkOutput("B.ref_end",   busB.o_ref_end,   mOff[1] == END_OFF);
            checkOutput("B.aref_cmd",  busB.o_aref_cmd,  expCmd(mOff[1]));
            checkOutput("B.aref_addr", busB.o_aref_addr, expAddr(mOff[1]));
            checkOutput("B.ref_miss",  busB.o_ref_miss,  mMiss[1]);
        end
    end

    task automatic applyStimulus(input int n, input bit randB);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (randB) refEn[1] = ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        int n;
        initEnd[0] = 1'b0;
        initEnd[1] = 1'b0;
        refEn[0]   = 1'b0;
        refEn[1]   = 1'b0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        checkEn = 1'b1;

        $display("[TB] init_end low, random ref_en");
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            refEn[0] = $urandom_range(0, 1);
            refEn[1] = $urandom_range(0, 1);
        end
        checkOutput("A.idle_req", busA.o_ref_req, 1'b0);
        checkOutput("A.idle_cmd", busA.o_aref_cmd, 4'b0111);

        $display("[TB] init_end high, A granted immediately");
        initEnd[0] = 1'b1;
        initEnd[1] = 1'b1;
        refEn[0]   = 1'b1;
        applyStimulus(3 * PER_A + 40, 1'b1);

        $display("[TB] A request left pending");
        refEn[0] = 1'b0;
        n = 0;
        while (!busA.o_ref_req && n < PER_A + 20) begin
            applyStimulus(1, 1'b1);
            n++;
        end
        checkOutput("A.req_wait", busA.o_ref_req, 1'b1);
        applyStimulus(1600, 1'b1);
        checkOutput("A.miss_sticky", busA.o_ref_miss, 1'b1);
        checkOutput("A.req_held", busA.o_ref_req, 1'b1);
        refEn[0] = 1'b1;
        applyStimulus(1, 1'b1);
        refEn[0] = 1'b0;
        applyStimulus(60, 1'b1);
        refEn[0] = 1'b1;

        $display("[TB] B grant on terminal count");
        refEn[1] = 1'b0;
        n = 0;
        while (!(mReq[1] && mOff[1] < 0 && (mElapsed[1] % PER_B) == PER_B - 1) && n < 100) begin
            applyStimulus(1, 1'b0);
            n++;
        end
        checkOutput("B.tc_wait", n < 100, 1'b1);
        refEn[1] = 1'b1;
        applyStimulus(1, 1'b0);
        refEn[1] = 1'b0;
        checkOutput("B.tc_req_kept", busB.o_ref_req, 1'b1);
        checkOutput("B.tc_pre", busB.o_aref_cmd, 4'b0010);
        refEn[1] = 1'b1;
        applyStimulus(60, 1'b0);

        $display("[TB] reset mid-sequence");
        n = 0;
        while (mOff[1] != 5 && n < 100) begin
            applyStimulus(1, 1'b0);
            n++;
        end
        checkOutput("B.mid_wait", n < 100, 1'b1);
        rst = 1'b1;
        applyStimulus(1, 1'b0);
        rst = 1'b0;
        checkOutput("B.rst_cmd", busB.o_aref_cmd, 4'b0111);
        checkOutput("B.rst_end", busB.o_ref_end, 1'b0);
        checkOutput("B.rst_req", busB.o_ref_req, 1'b0);
        applyStimulus(40, 1'b1);

        $display("[TB] random phase");
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 299) == 0) initEnd[0] = ~initEnd[0];
            if ($urandom_range(0, 299) == 0) initEnd[1] = ~initEnd[1];
            refEn[0] = ($urandom_range(0, 7) == 0);
            refEn[1] = $urandom_range(0, 1);
        end
        rst = 1'b0;
        applyStimulus(5, 1'b0);

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
